// File: rtl/fifo_sched.sv
// rtl/fifo_sched.sv - packet scheduler draining NUM_PRI FWFT queues into one stream
module fifo_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PRI    = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PRI-1:0]            q_ready,
  input  logic [NUM_PRI-1:0]            q_vld,
  input  logic [NUM_PRI-1:0]            q_sop,
  input  logic [NUM_PRI-1:0]            q_eop,
  input  logic [NUM_PRI*DATA_WIDTH-1:0] q_data,
  output logic [NUM_PRI-1:0]            q_next_data,
  input  logic [NUM_PRI-1:0]            cfg_en,
  input  logic                          cfg_rr,
  input  logic                          out_rdy,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic                          out_vld,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_PRI)-1:0]    out_pri,
  output logic                          busy,
  output logic                          err,
  output logic [15:0]                   pkt_cnt
);

  localparam int PW = $clog2(NUM_PRI);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         sel_q, sel_d;
  logic [PW-1:0]         last_q, last_d;
  logic [CW-1:0]         idle_q, idle_d;
  logic [15:0]           pkt_q, pkt_d;
  logic                  out_vld_q, out_vld_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  err_q, err_d;

  logic [NUM_PRI-1:0]    elig;
  logic [PW-1:0]         win;
  logic                  vld_sel, sop_sel, eop_sel;
  logic [DATA_WIDTH-1:0] data_sel;
  logic                  pop;
  logic                  timeout_hit;

  assign elig     = q_ready & cfg_en;
  assign vld_sel  = q_vld[sel_q];
  assign sop_sel  = q_sop[sel_q];
  assign eop_sel  = q_eop[sel_q];
  assign data_sel = q_data[sel_q*DATA_WIDTH +: DATA_WIDTH];

  // A word is popped on every XFER cycle where the latched queue presents one;
  // reset gates it so the reset edge itself never consumes a word.
  assign pop         = (state_q == XFER) && vld_sel && rst;
  assign timeout_hit = (state_q == XFER) && !vld_sel && (idle_q == CW'(TIMEOUT - 1));

  // Arbiter: lowest eligible index, or first eligible after last served when round robin
  always_comb begin
    int  idx;
    logic found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (cfg_rr) begin
      for (int k = 1; k <= NUM_PRI; k++) begin
        idx = int'(last_q) + k;
        if (idx >= NUM_PRI) idx = idx - NUM_PRI;
        if (!found && elig[idx]) begin
          win   = PW'(idx);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_PRI - 1; i >= 0; i--) begin
        if (elig[i]) win = PW'(i);
      end
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      last_q     <= PW'(NUM_PRI - 1);
      idle_q     <= '0;
      pkt_q      <= '0;
      out_vld_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      idle_q     <= idle_d;
      pkt_q      <= pkt_d;
      out_vld_q  <= out_vld_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (out_rdy && (|elig)) state_d = GRANT;
      GRANT:   state_d = XFER;
      XFER: begin
        if (pop && eop_sel)   state_d = DONE;
        else if (timeout_hit) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: grant latch, RR pointer, idle timer, counter, output word
  always_comb begin
    sel_d      = sel_q;
    last_d     = last_q;
    idle_d     = '0;
    pkt_d      = pkt_q;
    out_vld_d  = pop | timeout_hit;
    out_sop_d  = pop & sop_sel;
    out_eop_d  = pop ? eop_sel : timeout_hit;
    out_data_d = pop ? data_sel : '0;
    err_d      = timeout_hit;
    if (state_q == IDLE && state_d == GRANT) sel_d = win;
    if (state_q == DONE) begin
      last_d = sel_q;
      pkt_d  = pkt_q + 16'd1;
    end
    if (state_q == XFER && !vld_sel && !timeout_hit) idle_d = idle_q + CW'(1);
  end

  // Output logic: pop strobe only toward the latched queue during XFER
  always_comb begin
    q_next_data = '0;
    if (pop) q_next_data[sel_q] = 1'b1;
    busy = (state_q != IDLE);
  end

  assign out_vld  = out_vld_q;
  assign out_sop  = out_sop_q;
  assign out_eop  = out_eop_q;
  assign out_data = out_data_q;
  assign out_pri  = sel_q;
  assign err      = err_q;
  assign pkt_cnt  = pkt_q;

endmodule
